seq_writeback: RTL and testbench
================================

// Module: seq_writeback
// PURPOSE
// - Writeback stage of the SEQ Y86-64 core: owns the architectural register file (15 x 64b)
//   and commits valE/valM at each rising clk. Drives regmem0..regmem14 into decode.
// - Tracks sticky processor status (AOK/HLT/ADR/INS) and counts retired instructions.
// PARAMETERS
// - DATA_W     64      register/data width
// - RSP_IDX    14      stack-pointer register index
// - RSP_RESET  64'h0   stack-pointer value after reset; all other registers reset to 0
// - CNT_W      32      retired-instruction counter width
// PORTS
// - clk         in   1       single clock, rising edge
// - rst_n       in   1       asynchronous, active-low reset
// - wb_valid    in   1       one instruction presented for commit this cycle
// - icode       in   4       instruction code
// - rA, rB      in   4       register specifiers; 4'hF = none
// - cnd         in   1       condition from execute (cmovXX only)
// - valE        in   DATA_W  execute result
// - valM        in   DATA_W  memory read result
// - imem_error  in   1       fetch address error
// - dmem_error  in   1       data-memory address error
// - regmem0..14 out  DATA_W  registered register contents
// - stat        out  3       1=AOK 2=HLT 3=ADR 4=INS
// - retired     out  CNT_W   instructions committed while AOK
// BEHAVIOUR
// - Reset (async, rst_n=0): regmem* = 0 except regmem[RSP_IDX]=RSP_RESET; stat=AOK; retired=0.
//   Reset mid-operation discards the in-flight commit; no partial write.
// - Destination decode (combinational):
//   cmovXX(2): dstE=rB if cnd else none; irmovq(3), OPq(6): dstE=rB; mrmovq(5): dstM=rA;
//   call(8), ret(9), pushq(10): dstE=RSP_IDX; popq(11): dstE=RSP_IDX, dstM=rA;
//   halt(0), nop(1), rmmovq(4), jXX(7): none. Index 4'hF (and 15 generally) = no write.
// - Commit: on rising clk with wb_valid=1, stat==AOK and no fault this cycle:
//   regfile[dstE]<=valE, regfile[dstM]<=valM; latency 1 cycle (visible on regmem* next cycle).
// - dstE==dstM (popq %rsp): valM wins; exactly one write.
// - Fault classification for a wb_valid cycle, priority high->low:
//   imem_error|dmem_error -> ADR; icode>11 -> INS; icode==0 -> HLT; else AOK.
// - Status FSM: AOK -> {HLT,ADR,INS} per fault; HLT/ADR/INS are absorbing until reset.
//   The faulting instruction performs no register write and is not counted.
// - retired increments by 1 per committed instruction (incl. nop/jXX/rmmovq); wraps modulo 2^CNT_W.
// - wb_valid=0: no writes, stat and retired hold. Error inputs ignored when wb_valid=0.
// STRUCTURE
// - Shared package y86_pkg: icode constants (I_HALT..I_POPQ), RNONE=4'hF, stat encodings
//   (S_AOK=1,S_HLT=2,S_ADR=3,S_INS=4), stat_t typedef.
// - One sub-module: y86_regfile_2w (15 x DATA_W, two write ports with port-M priority,
//   async reset, flat read-out of all entries). Dest decode, status FSM, counter stay here.
// TESTING
// - irmovq rB=2 valE=64'h1234 wb_valid=1 -> regmem2=64'h1234 next cycle, retired=1.
// - popq rA=14 valE=8 valM=64'hAA -> regmem14=64'hAA (M wins), no other reg changes.
// - cmovXX rB=3 cnd=0 valE=5 -> regmem3 unchanged, retired increments; cnd=1 -> regmem3=5.
// - halt then irmovq rB=1 valE=7 -> stat=2, regmem1 unchanged, retired frozen, stays HLT.
// - dmem_error=1 with icode=0 -> stat=3 (ADR beats HLT); icode=12 -> stat=4, no write.
// - rst_n low mid-stream async (between edges) -> outputs zero immediately, regmem14=RSP_RESET, stat=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register "none" index and
// processor status encodings used across the SEQ core.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_t;

endpackage

// File: rtl/y86_regfile_2w.sv
// 15-entry register file with two write ports (port M has priority on a
// shared destination), asynchronous reset and a flat read-out of every entry.
module y86_regfile_2w #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       NREGS     = 15,
    parameter int unsigned       RSP_IDX   = 14,
    parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_e,
    input  logic [3:0]              dst_e,
    input  logic [DATA_W-1:0]       val_e,
    input  logic                    we_m,
    input  logic [3:0]              dst_m,
    input  logic [DATA_W-1:0]       val_m,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] regs [NREGS];

    // Per-entry select keeps out-of-range indices (15) from ever writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= (i == RSP_IDX) ? RSP_RESET : '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (we_m && dst_m == 4'(i))
                    regs[i] <= val_m;
                else if (we_e && dst_e == 4'(i))
                    regs[i] <= val_e;
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: rtl/seq_writeback.sv
// SEQ Y86-64 writeback stage: destination decode, register-file commit,
// sticky processor status and retired-instruction counter.
module seq_writeback
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       RSP_IDX   = 14,
    parameter logic [DATA_W-1:0] RSP_RESET = 64'h0,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              imem_error,
    input  logic              dmem_error,
    output logic [DATA_W-1:0] regmem0,
    output logic [DATA_W-1:0] regmem1,
    output logic [DATA_W-1:0] regmem2,
    output logic [DATA_W-1:0] regmem3,
    output logic [DATA_W-1:0] regmem4,
    output logic [DATA_W-1:0] regmem5,
    output logic [DATA_W-1:0] regmem6,
    output logic [DATA_W-1:0] regmem7,
    output logic [DATA_W-1:0] regmem8,
    output logic [DATA_W-1:0] regmem9,
    output logic [DATA_W-1:0] regmem10,
    output logic [DATA_W-1:0] regmem11,
    output logic [DATA_W-1:0] regmem12,
    output logic [DATA_W-1:0] regmem13,
    output logic [DATA_W-1:0] regmem14,
    output logic [2:0]        stat,
    output logic [CNT_W-1:0]  retired
);

    localparam int unsigned NREGS = 15;

    logic [3:0]              dst_e;
    logic [3:0]              dst_m;
    logic                    commit;
    stat_t                   stat_q;
    stat_t                   stat_d;
    logic [NREGS*DATA_W-1:0] regs_flat;

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_RRMOVQ:                  dst_e = cnd ? rB : RNONE;
            I_IRMOVQ, I_OPQ:           dst_e = rB;
            I_MRMOVQ:                  dst_m = rA;
            I_CALL, I_RET, I_PUSHQ:    dst_e = 4'(RSP_IDX);
            I_POPQ: begin
                dst_e = 4'(RSP_IDX);
                dst_m = rA;
            end
            default: ;
        endcase
    end

    // Fault priority ADR > INS > HLT; a faulting instruction never commits.
    always_comb begin
        stat_d = stat_q;
        commit = 1'b0;
        if (wb_valid && stat_q == S_AOK) begin
            if (imem_error || dmem_error)
                stat_d = S_ADR;
            else if (icode > I_POPQ)
                stat_d = S_INS;
            else if (icode == I_HALT)
                stat_d = S_HLT;
            else
                commit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_q <= S_AOK;
        else
            stat_q <= stat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (commit)
            retired <= retired + 1'b1;
    end

    assign stat = stat_q;

    y86_regfile_2w #(
        .DATA_W    (DATA_W),
        .NREGS     (NREGS),
        .RSP_IDX   (RSP_IDX),
        .RSP_RESET (RSP_RESET)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_e      (commit),
        .dst_e     (dst_e),
        .val_e     (valE),
        .we_m      (commit),
        .dst_m     (dst_m),
        .val_m     (valM),
        .regs_flat (regs_flat)
    );

    assign regmem0  = regs_flat[ 0*DATA_W +: DATA_W];
    assign regmem1  = regs_flat[ 1*DATA_W +: DATA_W];
    assign regmem2  = regs_flat[ 2*DATA_W +: DATA_W];
    assign regmem3  = regs_flat[ 3*DATA_W +: DATA_W];
    assign regmem4  = regs_flat[ 4*DATA_W +: DATA_W];
    assign regmem5  = regs_flat[ 5*DATA_W +: DATA_W];
    assign regmem6  = regs_flat[ 6*DATA_W +: DATA_W];
    assign regmem7  = regs_flat[ 7*DATA_W +: DATA_W];
    assign regmem8  = regs_flat[ 8*DATA_W +: DATA_W];
    assign regmem9  = regs_flat[ 9*DATA_W +: DATA_W];
    assign regmem10 = regs_flat[10*DATA_W +: DATA_W];
    assign regmem11 = regs_flat[11*DATA_W +: DATA_W];
    assign regmem12 = regs_flat[12*DATA_W +: DATA_W];
    assign regmem13 = regs_flat[13*DATA_W +: DATA_W];
    assign regmem14 = regs_flat[14*DATA_W +: DATA_W];

endmodule

// File: tb/tb_seq_writeback.sv
// Directed testbench for seq_writeback: hand-computed register, status and
// retired-count expectations for each instruction class and fault case.
module tb_seq_writeback;

    localparam logic [63:0] RSPR = 64'hF000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  rA = 4'hF;
    logic [3:0]  rB = 4'hF;
    logic        cnd = 1'b0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic        imem_error = 1'b0;
    logic        dmem_error = 1'b0;
    logic [63:0] rm [15];
    logic [63:0] wrm [15];
    logic [2:0]  stat, wstat;
    logic [31:0] retired;
    logic [3:0]  wretired;

    logic [63:0] exp_rf [15];
    logic [2:0]  exp_stat;
    logic [31:0] exp_ret;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_writeback #(.DATA_W(64), .RSP_IDX(14), .RSP_RESET(RSPR), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .imem_error(imem_error), .dmem_error(dmem_error),
        .regmem0(rm[0]), .regmem1(rm[1]), .regmem2(rm[2]), .regmem3(rm[3]), .regmem4(rm[4]),
        .regmem5(rm[5]), .regmem6(rm[6]), .regmem7(rm[7]), .regmem8(rm[8]), .regmem9(rm[9]),
        .regmem10(rm[10]), .regmem11(rm[11]), .regmem12(rm[12]), .regmem13(rm[13]),
        .regmem14(rm[14]), .stat(stat), .retired(retired)
    );

    // Narrow-counter instance for the wrap-around check.
    seq_writeback #(.DATA_W(64), .RSP_IDX(14), .RSP_RESET(RSPR), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .imem_error(imem_error), .dmem_error(dmem_error),
        .regmem0(wrm[0]), .regmem1(wrm[1]), .regmem2(wrm[2]), .regmem3(wrm[3]), .regmem4(wrm[4]),
        .regmem5(wrm[5]), .regmem6(wrm[6]), .regmem7(wrm[7]), .regmem8(wrm[8]), .regmem9(wrm[9]),
        .regmem10(wrm[10]), .regmem11(wrm[11]), .regmem12(wrm[12]), .regmem13(wrm[13]),
        .regmem14(wrm[14]), .stat(wstat), .retired(wretired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 15; i++)
            check($sformatf("%s r%0d", tag, i), rm[i], exp_rf[i]);
        check({tag, " stat"}, {61'd0, stat}, {61'd0, exp_stat});
        check({tag, " retired"}, {32'd0, retired}, {32'd0, exp_ret});
    endtask

    task automatic exp_reset();
        for (int i = 0; i < 15; i++) exp_rf[i] = '0;
        exp_rf[14] = RSPR;
        exp_stat = 3'd1;
        exp_ret = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wb_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_reset();
    endtask

    // One valid instruction presented for a single rising edge.
    task automatic step(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [63:0] e, input logic [63:0] m,
                        input logic ime, input logic dme, input logic v);
        @(negedge clk);
        icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
        imem_error = ime; dmem_error = dme; wb_valid = v;
        @(posedge clk);
        #1;
        wb_valid = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    endtask

    initial begin
        exp_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        step(4'h3, 4'hF, 4'h2, 0, 64'h1234, 64'h0, 0, 0, 1);
        exp_rf[2] = 64'h1234; exp_ret = 1;
        check_all("irmovq");

        step(4'hB, 4'hE, 4'hF, 0, 64'h8, 64'hAA, 0, 0, 1);
        exp_rf[14] = 64'hAA; exp_ret = 2;
        check_all("popq_rsp");

        step(4'hB, 4'h5, 4'hF, 0, 64'h10, 64'h55, 0, 0, 1);
        exp_rf[14] = 64'h10; exp_rf[5] = 64'h55; exp_ret = 3;
        check_all("popq_r5");

        step(4'h2, 4'h1, 4'h3, 0, 64'h5, 64'h0, 0, 0, 1);
        exp_ret = 4;
        check_all("cmov_nc");

        step(4'h2, 4'h1, 4'h3, 1, 64'h5, 64'h0, 0, 0, 1);
        exp_rf[3] = 64'h5; exp_ret = 5;
        check_all("cmov_c");

        step(4'h6, 4'h1, 4'h4, 0, 64'h99, 64'h0, 0, 0, 1);
        exp_rf[4] = 64'h99; exp_ret = 6;
        check_all("opq");

        step(4'h5, 4'h6, 4'h7, 0, 64'h11, 64'h66, 0, 0, 1);
        exp_rf[6] = 64'h66; exp_ret = 7;
        check_all("mrmovq");

        step(4'h8, 4'hF, 4'hF, 0, 64'h77, 64'h0, 0, 0, 1);
        exp_rf[14] = 64'h77; exp_ret = 8;
        check_all("call");

        step(4'hA, 4'h1, 4'hF, 0, 64'h70, 64'h0, 0, 0, 1);
        exp_rf[14] = 64'h70; exp_ret = 9;
        check_all("pushq");

        step(4'h9, 4'hF, 4'hF, 0, 64'h78, 64'h1, 0, 0, 1);
        exp_rf[14] = 64'h78; exp_ret = 10;
        check_all("ret");

        step(4'h1, 4'h2, 4'h2, 1, 64'hFF, 64'hFF, 0, 0, 1);
        exp_ret = 11;
        check_all("nop");

        step(4'h4, 4'h3, 4'h2, 1, 64'hFFF, 64'hFFF, 0, 0, 1);
        exp_ret = 12;
        check_all("rmmovq");

        step(4'h7, 4'h2, 4'h2, 1, 64'hABC, 64'hABC, 0, 0, 1);
        exp_ret = 13;
        check_all("jxx");

        step(4'h3, 4'hF, 4'hF, 0, 64'h5, 64'h0, 0, 0, 1);
        exp_ret = 14;
        check_all("irmovq_rnone");

        step(4'h3, 4'hF, 4'h1, 0, 64'h7, 64'h0, 0, 1, 0);
        check_all("idle");

        step(4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0, 1);
        exp_stat = 3'd2;
        check_all("halt");

        step(4'h3, 4'hF, 4'h1, 0, 64'h7, 64'h0, 0, 0, 1);
        check_all("after_halt");

        // Reset asserted between edges while a commit is pending.
        @(negedge clk);
        icode = 4'h3; rB = 4'h1; valE = 64'h7; wb_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        wb_valid = 1'b0;
        rst_n = 1'b1;

        step(4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 1, 1);
        exp_stat = 3'd3;
        check_all("adr_over_hlt");
        step(4'h3, 4'hF, 4'h2, 0, 64'h9, 64'h0, 0, 0, 1);
        check_all("adr_sticky");

        do_reset();
        step(4'h3, 4'hF, 4'h2, 0, 64'h9, 64'h0, 1, 0, 1);
        exp_stat = 3'd3;
        check_all("imem_adr");

        do_reset();
        step(4'hC, 4'hF, 4'h2, 0, 64'h9, 64'h0, 0, 0, 1);
        exp_stat = 3'd4;
        check_all("ins");
        step(4'h3, 4'hF, 4'h2, 0, 64'h9, 64'h0, 0, 0, 1);
        check_all("ins_sticky");

        do_reset();
        for (int k = 0; k < 18; k++)
            step(4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0, 1);
        exp_ret = 18;
        check_all("nops");
        check("wrap retired", {60'd0, wretired}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
